// File: rtl/logic_exec_stage_if.sv
// Handshake and datapath bundle between the logical-mode execute stage and its environment.
// The slave modport is the stage's view; master is the driver/bench side.
interface logic_exec_stage_if;
    logic       instrValid;
    logic [7:0] instr;
    logic       instrReady;
    logic       dataValid;
    logic [7:0] dataIn;
    logic       dataReady;
    logic       accLoad;
    logic [7:0] accIn;
    logic [2:0] luOpcode;
    logic [7:0] luOperandA;
    logic [7:0] luOperandB;
    logic [7:0] luResult;
    logic [7:0] acc;
    logic       zeroFlag;
    logic       negFlag;
    logic       done;
    logic       illegal;

    modport slave (
        input  instrValid, instr, dataValid, dataIn, accLoad, accIn, luResult,
        output instrReady, dataReady, luOpcode, luOperandA, luOperandB,
               acc, zeroFlag, negFlag, done, illegal
    );

    modport master (
        output instrValid, instr, dataValid, dataIn, accLoad, accIn, luResult,
        input  instrReady, dataReady, luOpcode, luOperandA, luOperandB,
               acc, zeroFlag, negFlag, done, illegal
    );
endinterface

// File: rtl/logic_exec_stage.sv
// Execute-stage sequencer for logical-mode instructions: fetches operand B, drives the
// logical unit from registers and writes its result into the accumulator and Z/N flags.
module logic_exec_stage #(
    parameter logic [1:0] MODE_LOGIC = 2'b01
) (
    input logic                  clock,
    input logic                  reset,
    logic_exec_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_legal;
    logic       w_accept;
    logic       w_data_hs;

    logic [7:0] r_acc;
    logic       r_zero;
    logic       r_neg;
    logic [2:0] r_opcode;
    logic [7:0] r_opa;
    logic [7:0] r_opb;
    logic       r_illegal;

    // Ops 100-111 are rejected even though the logical unit would answer them.
    assign w_legal   = (bus.instr[7:6] == MODE_LOGIC) && (bus.instr[5:2] == 4'b0000);
    assign w_accept  = (r_state == S_IDLE) && bus.instrValid && !bus.accLoad;
    assign w_data_hs = (r_state == S_FETCH) && bus.dataValid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_legal ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (w_data_hs) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.instrReady = 1'b0;
        bus.dataReady  = 1'b0;
        bus.done       = 1'b0;
        bus.illegal    = 1'b0;
        case (r_state)
            S_IDLE:  bus.instrReady = !bus.accLoad;
            S_FETCH: bus.dataReady  = 1'b1;
            S_DONE: begin
                bus.done    = 1'b1;
                bus.illegal = r_illegal;
            end
            default: ;
        endcase
    end

    // Operand registers hold from FETCH entry through EXEC so the logical unit sees stable inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc     <= 8'h00;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_opcode  <= 3'b000;
            r_opa     <= 8'h00;
            r_opb     <= 8'h00;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.accLoad) begin
                        r_acc <= bus.accIn;
                    end else if (bus.instrValid) begin
                        if (w_legal) begin
                            r_opcode  <= bus.instr[2:0];
                            r_opa     <= r_acc;
                            r_illegal <= 1'b0;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.dataValid) begin
                        r_opb <= bus.dataIn;
                    end
                end
                S_EXEC: begin
                    r_acc  <= bus.luResult;
                    r_zero <= (bus.luResult == 8'h00);
                    r_neg  <= bus.luResult[7];
                end
                default: ;
            endcase
        end
    end

    assign bus.acc        = r_acc;
    assign bus.zeroFlag   = r_zero;
    assign bus.negFlag    = r_neg;
    assign bus.luOpcode   = r_opcode;
    assign bus.luOperandA = r_opa;
    assign bus.luOperandB = r_opb;

endmodule

// File: tb/tb_logic_exec_stage.sv
// Directed bench for logic_exec_stage with a behavioural logical unit on the result path.
module tb_logic_exec_stage;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   ready_cnt;

    logic_exec_stage_if bus ();

    logic_exec_stage #(.MODE_LOGIC(2'b01)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Logical unit: AND, OR, NAND, NOR; ops 1xx return zero.
    always_comb begin
        case (bus.luOpcode)
            3'b000:  bus.luResult = bus.luOperandA & bus.luOperandB;
            3'b001:  bus.luResult = bus.luOperandA | bus.luOperandB;
            3'b010:  bus.luResult = ~(bus.luOperandA & bus.luOperandB);
            3'b011:  bus.luResult = ~(bus.luOperandA | bus.luOperandB);
            default: bus.luResult = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_acc(input logic [7:0] v);
        bus.accLoad = 1'b1;
        bus.accIn   = v;
        tick();
        bus.accLoad = 1'b0;
    endtask

    // Issues a legal instruction with operand ready immediately; returns in the DONE cycle.
    task automatic run_legal(input logic [7:0] ins, input logic [7:0] data);
        bus.instrValid = 1'b1;
        bus.instr      = ins;
        bus.dataValid  = 1'b1;
        bus.dataIn     = data;
        tick();
        bus.instrValid = 1'b0;
        tick();
        bus.dataValid  = 1'b0;
        check("exec_no_done", {15'd0, bus.done}, 16'd0);
        tick();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.instrValid = 1'b0;
        bus.instr      = 8'h00;
        bus.dataValid  = 1'b0;
        bus.dataIn     = 8'h00;
        bus.accLoad    = 1'b0;
        bus.accIn      = 8'h00;
        tick();
        tick();

        check("rst_acc",     {8'd0, bus.acc}, 16'h0000);
        check("rst_flags",   {14'd0, bus.zeroFlag, bus.negFlag}, 16'd0);
        check("rst_opc",     {13'd0, bus.luOpcode}, 16'd0);
        check("rst_opab",    {bus.luOperandA, bus.luOperandB}, 16'h0000);
        check("rst_ctl",     {12'd0, bus.done, bus.illegal, bus.dataReady, bus.instrReady}, 16'b0001);
        reset = 1'b0;
        tick();

        // AND: F0 & 3C
        bus.accLoad = 1'b1;
        bus.accIn   = 8'hF0;
        #1;
        check("ld_iready_low", {15'd0, bus.instrReady}, 16'd0);
        tick();
        bus.accLoad = 1'b0;
        check("ld_acc", {8'd0, bus.acc}, 16'h00F0);
        bus.instrValid = 1'b1;
        bus.instr      = 8'h40;
        bus.dataValid  = 1'b1;
        bus.dataIn     = 8'h3C;
        #1;
        check("and_iready", {15'd0, bus.instrReady}, 16'd1);
        tick();
        bus.instrValid = 1'b0;
        check("and_fetch", {14'd0, bus.dataReady, bus.instrReady}, 16'b10);
        check("and_opc_opa", {5'd0, bus.luOpcode, bus.luOperandA}, 16'h00F0);
        check("and_fetch_nodone", {15'd0, bus.done}, 16'd0);
        tick();
        bus.dataValid = 1'b0;
        check("and_opb", {8'd0, bus.luOperandB}, 16'h003C);
        check("and_exec_ctl", {13'd0, bus.dataReady, bus.instrReady, bus.done}, 16'd0);
        tick();
        check("and_acc", {8'd0, bus.acc}, 16'h0030);
        check("and_zn", {14'd0, bus.zeroFlag, bus.negFlag}, 16'b00);
        check("and_done", {14'd0, bus.done, bus.illegal}, 16'b10);
        tick();
        check("and_after", {14'd0, bus.done, bus.instrReady}, 16'b01);

        // NOR: 0F nor F0 with five stall cycles, accLoad attempted mid-FETCH
        load_acc(8'h0F);
        bus.instrValid = 1'b1;
        bus.instr      = 8'h43;
        tick();
        bus.instrValid = 1'b0;
        ready_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bus.accLoad = (i == 2);
            bus.accIn   = 8'hAA;
            #1;
            if (bus.dataReady === 1'b1) ready_cnt++;
            tick();
        end
        bus.accLoad = 1'b0;
        check("nor_stall_acc", {8'd0, bus.acc}, 16'h000F);
        bus.dataValid = 1'b1;
        bus.dataIn    = 8'hF0;
        #1;
        if (bus.dataReady === 1'b1) ready_cnt++;
        tick();
        bus.dataValid = 1'b0;
        check("nor_ready_cycles", 16'(ready_cnt), 16'd6);
        check("nor_opb", {8'd0, bus.luOperandB}, 16'h00F0);
        check("nor_exec_dready", {15'd0, bus.dataReady}, 16'd0);
        tick();
        check("nor_acc", {8'd0, bus.acc}, 16'h0000);
        check("nor_zn", {14'd0, bus.zeroFlag, bus.negFlag}, 16'b10);
        check("nor_done", {14'd0, bus.done, bus.illegal}, 16'b10);
        tick();

        // NAND then OR chained through the accumulator
        load_acc(8'hFF);
        run_legal(8'h42, 8'h0F);
        check("nand_acc", {8'd0, bus.acc}, 16'h00F0);
        check("nand_zn", {14'd0, bus.zeroFlag, bus.negFlag}, 16'b01);
        tick();
        run_legal(8'h41, 8'h01);
        check("or_opa", {8'd0, bus.luOperandA}, 16'h00F0);
        check("or_acc", {8'd0, bus.acc}, 16'h00F1);
        check("or_zn", {14'd0, bus.zeroFlag, bus.negFlag}, 16'b01);
        tick();

        // Illegal encodings: op 1xx, reserved bits set, wrong mode
        load_acc(8'h55);
        begin
            logic [7:0] bad [3];
            bad[0] = 8'h44;
            bad[1] = 8'h48;
            bad[2] = 8'h80;
            for (int k = 0; k < 3; k++) begin
                bus.instrValid = 1'b1;
                bus.instr      = bad[k];
                tick();
                bus.instrValid = 1'b0;
                check("ill_done", {13'd0, bus.done, bus.illegal, bus.dataReady}, 16'b110);
                check("ill_acc", {8'd0, bus.acc}, 16'h0055);
                check("ill_zn", {14'd0, bus.zeroFlag, bus.negFlag}, 16'b01);
                check("ill_regs", {5'd0, bus.luOpcode, bus.luOperandB}, {5'd0, 3'b001, 8'h01});
                tick();
                check("ill_after", {13'd0, bus.done, bus.illegal, bus.dataReady}, 16'd0);
            end
        end

        // accLoad wins over a simultaneous instruction offer
        bus.accLoad    = 1'b1;
        bus.accIn      = 8'h3C;
        bus.instrValid = 1'b1;
        bus.instr      = 8'h40;
        #1;
        check("prio_iready", {15'd0, bus.instrReady}, 16'd0);
        tick();
        bus.accLoad = 1'b0;
        check("prio_not_taken", {14'd0, bus.dataReady, bus.done}, 16'd0);
        check("prio_acc", {8'd0, bus.acc}, 16'h003C);
        tick();
        bus.instrValid = 1'b0;
        check("prio_taken", {14'd0, bus.dataReady, bus.instrReady}, 16'b10);
        check("prio_opa", {8'd0, bus.luOperandA}, 16'h003C);
        bus.dataValid = 1'b1;
        bus.dataIn    = 8'hFF;
        tick();
        bus.dataValid = 1'b0;
        tick();
        check("prio_acc_res", {8'd0, bus.acc}, 16'h003C);
        tick();

        // Asynchronous reset while waiting in FETCH
        bus.instrValid = 1'b1;
        bus.instr      = 8'h41;
        tick();
        bus.instrValid = 1'b0;
        check("rf_fetch", {15'd0, bus.dataReady}, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rf_ctl", {12'd0, bus.done, bus.illegal, bus.dataReady, bus.instrReady}, 16'b0001);
        check("rf_acc", {8'd0, bus.acc}, 16'h0000);
        check("rf_opab", {bus.luOperandA, bus.luOperandB}, 16'h0000);
        check("rf_opc_zn", {11'd0, bus.luOpcode, bus.zeroFlag, bus.negFlag}, 16'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rf_nodone", {15'd0, bus.done}, 16'd0);
        run_legal(8'h41, 8'h80);
        check("rf_or_acc", {8'd0, bus.acc}, 16'h0080);
        check("rf_or_zn", {14'd0, bus.zeroFlag, bus.negFlag}, 16'b01);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
